// File: rtl/dram_arb_pkg.sv
// ============================================================================
// Module      : dram_arb_pkg
// Description : Shared constants and types for the two-port data-memory
//               arbiter (memory widths, write-control encodings, owner
//               states, requester indices).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dram_arb_pkg;

    // Default memory geometry: 512 KiB byte-wide data memory
    localparam int DEF_ADDR_W = 19;
    localparam int DEF_DATA_W = 8;

    // Memory write-control encodings; 2'b01 and 2'b11 are never produced
    localparam logic [1:0] MEM_WR = 2'b10;
    localparam logic [1:0] MEM_RD = 2'b00;

    // Requester indices
    localparam int REQ_CORE = 0;
    localparam int REQ_LDR  = 1;

    // Bus ownership state
    typedef enum logic [1:0] {
        FREE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/dram_arb_pick.sv
// ============================================================================
// Module      : dram_arb_pick
// Description : Combinational 2-way picker producing a one-hot grant.
//               With DRAM_ARB_RR_EN defined the ptr input selects which
//               requester has priority (round robin); otherwise the core
//               (requester 0) always wins and no ptr port exists.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_arb_pick
    import dram_arb_pkg::*;
(
    input  logic [1:0] req,
`ifdef DRAM_ARB_RR_EN
    input  logic       ptr,
`endif
    output logic [1:0] gnt
);

    // Pick at most one requester; priority depends on the build
    always_comb begin
        gnt = 2'b00;
`ifdef DRAM_ARB_RR_EN
        if (ptr == 1'b0) begin
            if (req[REQ_CORE])     gnt[REQ_CORE] = 1'b1;
            else if (req[REQ_LDR]) gnt[REQ_LDR]  = 1'b1;
        end else begin
            if (req[REQ_LDR])       gnt[REQ_LDR]  = 1'b1;
            else if (req[REQ_CORE]) gnt[REQ_CORE] = 1'b1;
        end
`else
        if (req[REQ_CORE])     gnt[REQ_CORE] = 1'b1;
        else if (req[REQ_LDR]) gnt[REQ_LDR]  = 1'b1;
`endif
    end

endmodule

`default_nettype wire

// File: rtl/dram_arbiter.sv
// ============================================================================
// Module      : dram_arbiter
// Description : Shares the single byte-wide data-memory port between the
//               processor core (requester 0) and the image loader
//               (requester 1). One command per cycle, registered onto the
//               memory pins one cycle after grant; read data returns two
//               cycles after grant with a one-hot valid strobe. A requester
//               holding lock keeps ownership for multi-byte sequences.
//               Build option: DRAM_ARB_RR_EN selects round-robin arbitration
//               in FREE; undefined gives fixed core priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_arbiter #(
    parameter int ADDR_W = dram_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = dram_arb_pkg::DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [1:0]        lock_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [1:0]        mem_write_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    import dram_arb_pkg::*;

    owner_t              r_owner;
    owner_t              w_owner_nxt;
    logic [1:0]          w_pick_gnt;
    logic [1:0]          w_gnt;
    logic                w_sel;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [1:0]          r_mem_write;
    logic                r_tag_vld;
    logic                r_tag_id;
    logic [1:0]          r_rvalid;

`ifdef DRAM_ARB_RR_EN
    logic                r_ptr;

    dram_arb_pick u_pick (
        .req (req_i),
        .ptr (r_ptr),
        .gnt (w_pick_gnt)
    );

    // Round-robin pointer: after a grant from FREE, favour the other side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if ((r_owner == FREE) && (w_gnt != 2'b00)) begin
            r_ptr <= w_gnt[REQ_CORE];
        end
    end
`else
    dram_arb_pick u_pick (
        .req (req_i),
        .gnt (w_pick_gnt)
    );
`endif

    // Owner state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= FREE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // Grant and next owner; the cycle that releases a lock is still arbitrated as owned
    always_comb begin
        w_gnt       = 2'b00;
        w_owner_nxt = r_owner;
        case (r_owner)
            FREE: begin
                w_gnt = w_pick_gnt;
                if (w_gnt[REQ_CORE] && lock_i[REQ_CORE]) begin
                    w_owner_nxt = OWN0;
                end else if (w_gnt[REQ_LDR] && lock_i[REQ_LDR]) begin
                    w_owner_nxt = OWN1;
                end
            end
            OWN0: begin
                w_gnt[REQ_CORE] = req_i[REQ_CORE];
                if (!lock_i[REQ_CORE] || !req_i[REQ_CORE]) begin
                    w_owner_nxt = FREE;
                end
            end
            OWN1: begin
                w_gnt[REQ_LDR] = req_i[REQ_LDR];
                if (!lock_i[REQ_LDR] || !req_i[REQ_LDR]) begin
                    w_owner_nxt = FREE;
                end
            end
            default: begin
                w_owner_nxt = FREE;
            end
        endcase
        if (!rst_n) begin
            w_gnt = 2'b00;
        end
    end

    // Mux the winning requester's command fields
    always_comb begin
        w_sel       = w_gnt[REQ_LDR];
        w_sel_we    = w_sel ? we_i[REQ_LDR] : we_i[REQ_CORE];
        w_sel_addr  = w_sel ? addr1_i  : addr0_i;
        w_sel_wdata = w_sel ? wdata1_i : wdata0_i;
    end

    // Command register: load on grant, otherwise idle read with held address/data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_write <= MEM_RD;
        end else if (w_gnt != 2'b00) begin
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_write <= w_sel_we ? MEM_WR : MEM_RD;
        end else begin
            r_mem_write <= MEM_RD;
        end
    end

    // Read tag pipeline: stage 1 tracks the command on the pins, stage 2 the returned data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= 1'b0;
            r_tag_id  <= 1'b0;
            r_rvalid  <= 2'b00;
        end else begin
            r_tag_vld <= (w_gnt != 2'b00) && !w_sel_we;
            r_tag_id  <= w_sel;
            r_rvalid  <= r_tag_vld ? (r_tag_id ? 2'b10 : 2'b01) : 2'b00;
        end
    end

    assign gnt_o       = w_gnt;
    assign rvalid_o    = r_rvalid;
    assign rdata_o     = mem_rdata_i;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_write_o = r_mem_write;

endmodule

`default_nettype wire

// File: tb/tb_dram_arbiter.sv
// ============================================================================
// Module      : tb_dram_arbiter
// Description : Self-checking bench for dram_arbiter with a behavioural
//               one-cycle synchronous byte memory and a read-data scoreboard.
//               Expectations for DRAM_ARB_RR_EN follow the same macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_i, we_i, lock_i;
    logic [ADDR_W-1:0] addr0_i, addr1_i;
    logic [DATA_W-1:0] wdata0_i, wdata1_i;
    logic [1:0]        gnt_o, rvalid_o, mem_write_o;
    logic [DATA_W-1:0] rdata_o, mem_wdata_o, mem_rdata;
    logic [ADDR_W-1:0] mem_addr_o;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    exp_t              sb_q[$];
    int                n_checks;
    int                n_errors;

    dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .we_i        (we_i),
        .lock_i      (lock_i),
        .addr0_i     (addr0_i),
        .addr1_i     (addr1_i),
        .wdata0_i    (wdata0_i),
        .wdata1_i    (wdata1_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_write_o (mem_write_o),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: write on 2'b10, registered read every cycle
    always @(posedge clk) begin
        if (mem_write_o == 2'b10) mem[mem_addr_o] <= mem_wdata_o;
        mem_rdata <= mem[mem_addr_o];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs after the edge, then wait to the sampling edge
    task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                         input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                         input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        @(posedge clk);
        #1;
        req_i = r; we_i = w; lock_i = l;
        addr0_i = a0; addr1_i = a1; wdata0_i = d0; wdata1_i = d1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    endtask

    // Scoreboard monitor: every read strobe must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (|rvalid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rvalid_unexpected: got rvalid 0x%0h expected none at %0t", rvalid_o, $time);
            end else begin
                e = sb_q.pop_front();
                chk("rvalid_id", {30'd0, rvalid_o}, e.id ? 32'h2 : 32'h1);
                chk("rdata", {24'd0, rdata_o}, {24'd0, e.data});
            end
        end
    end

    initial begin
        logic [1:0] exp_g;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        mem[0] = 8'h5A; mem[1] = 8'h03; mem[2] = 8'hC4; mem[3] = 8'h7E;
        rst_n = 1'b0;
        req_i = 2'b00; we_i = 2'b00; lock_i = 2'b00;
        addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;

        // Reset state, with both requesting to show the grant is suppressed
        repeat (2) @(posedge clk);
        #1 req_i = 2'b11;
        @(negedge clk);
        chk("rst_gnt", {30'd0, gnt_o}, 32'h0);
        chk("rst_mem_write", {30'd0, mem_write_o}, 32'h0);
        chk("rst_mem_addr", {13'd0, mem_addr_o}, 32'h0);
        chk("rst_mem_wdata", {24'd0, mem_wdata_o}, 32'h0);
        chk("rst_rvalid", {30'd0, rvalid_o}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1; req_i = 2'b00;

        // A: single core read of address 1
        drive(2'b01, 2'b00, 2'b00, 19'd1, '0, '0, '0);
        chk("A_gnt", {30'd0, gnt_o}, 32'h1);
        sb_q.push_back('{id: 1'b0, data: 8'h03});
        idle(1);
        chk("A_mem_write", {30'd0, mem_write_o}, 32'h0);
        chk("A_mem_addr", {13'd0, mem_addr_o}, 32'h1);
        idle(1);
        chk("A_rvalid_latency", {30'd0, rvalid_o}, 32'h1);
        chk("A_addr_hold", {13'd0, mem_addr_o}, 32'h1);

        // B: write 0xA5 to top address, read it back on the next cycle
        drive(2'b01, 2'b01, 2'b00, 19'h7FFFF, '0, 8'hA5, '0);
        chk("B_gnt_wr", {30'd0, gnt_o}, 32'h1);
        drive(2'b01, 2'b00, 2'b00, 19'h7FFFF, '0, 8'hA5, '0);
        chk("B_gnt_rd", {30'd0, gnt_o}, 32'h1);
        chk("B_mem_write_wr", {30'd0, mem_write_o}, 32'h2);
        chk("B_mem_addr", {13'd0, mem_addr_o}, 32'h7FFFF);
        chk("B_mem_wdata", {24'd0, mem_wdata_o}, 32'hA5);
        sb_q.push_back('{id: 1'b0, data: 8'hA5});
        idle(1);
        chk("B_mem_write_rd", {30'd0, mem_write_o}, 32'h0);
        idle(2);

        // Reset pulse returns the round-robin pointer to the core
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // C: continuous contention, no lock; core reads 2, loader reads 3
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 2'b00, 2'b00, 19'd2, 19'd3, '0, '0);
`ifdef DRAM_ARB_RR_EN
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            chk("C_gnt", {30'd0, gnt_o}, {30'd0, exp_g});
            if (exp_g == 2'b01) sb_q.push_back('{id: 1'b0, data: 8'hC4});
            else                sb_q.push_back('{id: 1'b1, data: 8'h7E});
        end
        idle(3);

        // D: loader locks for reads of 0..3 while the core waits for address 0
        drive(2'b10, 2'b00, 2'b10, 19'd0, 19'd0, '0, '0);
        chk("D_gnt0", {30'd0, gnt_o}, 32'h2);
        sb_q.push_back('{id: 1'b1, data: 8'h5A});
        drive(2'b11, 2'b00, 2'b10, 19'd0, 19'd1, '0, '0);
        chk("D_gnt1", {30'd0, gnt_o}, 32'h2);
        sb_q.push_back('{id: 1'b1, data: 8'h03});
        drive(2'b11, 2'b00, 2'b10, 19'd0, 19'd2, '0, '0);
        chk("D_gnt2", {30'd0, gnt_o}, 32'h2);
        sb_q.push_back('{id: 1'b1, data: 8'hC4});
        drive(2'b11, 2'b00, 2'b00, 19'd0, 19'd3, '0, '0);
        chk("D_gnt3_unlock", {30'd0, gnt_o}, 32'h2);
        sb_q.push_back('{id: 1'b1, data: 8'h7E});
        drive(2'b01, 2'b00, 2'b00, 19'd0, 19'd0, '0, '0);
        chk("D_core_after", {30'd0, gnt_o}, 32'h1);
        sb_q.push_back('{id: 1'b0, data: 8'h5A});
        idle(3);

        // E: loader locked read, then reset before its data returns
        drive(2'b10, 2'b00, 2'b10, 19'd0, 19'd1, '0, '0);
        chk("E_gnt", {30'd0, gnt_o}, 32'h2);
        @(posedge clk);
        #1 rst_n = 1'b0; req_i = 2'b00; lock_i = 2'b00;
        @(negedge clk);
        chk("E_rst_rvalid", {30'd0, rvalid_o}, 32'h0);
        chk("E_rst_mem_write", {30'd0, mem_write_o}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1; req_i = 2'b01; addr0_i = 19'd1;
        @(negedge clk);
        chk("E_no_rvalid", {30'd0, rvalid_o}, 32'h0);
        chk("E_core_gnt", {30'd0, gnt_o}, 32'h1);
        sb_q.push_back('{id: 1'b0, data: 8'h03});
        idle(4);

        chk("sb_drained", sb_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
